// File: rtl/ula_pkg.sv
// ULA operation codes and decode constants.
// Shared by the ALU-control stage and the ULA.
package ula_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_ADDU  = 4'b0100;
   localparam logic [3:0] OP_SUBU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_LUI   = 4'b1010;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_SLTU  = 4'b1101;
   // Reserved: never emitted by the control stage.
   localparam logic [3:0] OP_BREAK = 4'b1111;

   localparam logic [1:0] CLS_ADD = 2'b00;
   localparam logic [1:0] CLS_SUB = 2'b01;
   localparam logic [1:0] CLS_R   = 2'b10;
   localparam logic [1:0] CLS_I   = 2'b11;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_BREAK = 6'b001101;

   localparam logic [5:0] OC_ADDI  = 6'b001000;
   localparam logic [5:0] OC_ADDIU = 6'b001001;
   localparam logic [5:0] OC_SLTI  = 6'b001010;
   localparam logic [5:0] OC_SLTIU = 6'b001011;
   localparam logic [5:0] OC_ANDI  = 6'b001100;
   localparam logic [5:0] OC_ORI   = 6'b001101;
   localparam logic [5:0] OC_XORI  = 6'b001110;
   localparam logic [5:0] OC_LUI   = 6'b001111;

endpackage

// File: rtl/ula_ctrl_if.sv
// Handshake bundle between main control, the
// ALU-control stage and the ULA.
interface ula_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [5:0]       opcode;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       op;
   logic [TAG_W-1:0] tag_out;
   logic             illegal;
   logic             halt;

   modport slave (
      input  in_valid, alu_op, funct, opcode, tag_in, out_ready,
      output in_ready, out_valid, op, tag_out, illegal, halt
   );

   modport master (
      output in_valid, alu_op, funct, opcode, tag_in, out_ready,
      input  in_ready, out_valid, op, tag_out, illegal, halt
   );
endinterface

// File: rtl/ula_op_decode.sv
// Combinational map from control fields to a ULA
// op, flagging unknown encodings and break.
module ula_op_decode
   import ula_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   input  logic [5:0] opcode_i,
   output logic [3:0] op_o,
   output logic       illegal_o,
   output logic       is_break_o
);

   // Class first, then funct or opcode within it.
   always_comb begin
      op_o       = OP_AND;
      illegal_o  = 1'b0;
      is_break_o = 1'b0;
      unique case (alu_op_i)
         CLS_ADD: op_o = OP_ADD;
         CLS_SUB: op_o = OP_SUB;
         CLS_R: begin
            case (funct_i)
               F_ADD:   op_o = OP_ADD;
               F_ADDU:  op_o = OP_ADDU;
               F_SUB:   op_o = OP_SUB;
               F_SUBU:  op_o = OP_SUBU;
               F_AND:   op_o = OP_AND;
               F_OR:    op_o = OP_OR;
               F_XOR:   op_o = OP_XOR;
               F_NOR:   op_o = OP_NOR;
               F_SLT:   op_o = OP_SLT;
               F_SLTU:  op_o = OP_SLTU;
               F_MULT:  op_o = OP_MULT;
               F_MULTU: op_o = OP_MULTU;
               F_BREAK: is_break_o = 1'b1;
               default: illegal_o = 1'b1;
            endcase
         end
         CLS_I: begin
            case (opcode_i)
               OC_ADDI:  op_o = OP_ADD;
               OC_ADDIU: op_o = OP_ADDU;
               OC_SLTI:  op_o = OP_SLT;
               OC_SLTIU: op_o = OP_SLTU;
               OC_ANDI:  op_o = OP_AND;
               OC_ORI:   op_o = OP_OR;
               OC_XORI:  op_o = OP_XOR;
               OC_LUI:   op_o = OP_LUI;
               default:  illegal_o = 1'b1;
            endcase
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/ula_ctrl.sv
// ALU-control stage: decode on push, 2-entry
// output buffer, sticky halt on break.
module ula_ctrl
   import ula_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input logic   clock,
   input logic   reset,
   ula_ctrl_if.slave bus
);

   logic [1:0]       count_q, count_d;
   logic             halt_q, halt_d;
   logic [3:0]       op0_q, op0_d, op1_q, op1_d;
   logic             ill0_q, ill0_d, ill1_q, ill1_d;
   logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;

   logic [3:0] dec_op;
   logic       dec_ill;
   logic       dec_brk;
   logic       rdy;
   logic       vld;
   logic       accept;
   logic       push;
   logic       pop;
   logic       trap;

   ula_op_decode u_dec (
      .alu_op_i   (bus.alu_op),
      .funct_i    (bus.funct),
      .opcode_i   (bus.opcode),
      .op_o       (dec_op),
      .illegal_o  (dec_ill),
      .is_break_o (dec_brk)
   );

   // Ready depends on registers only.
   assign rdy    = (count_q != 2'd2) && !halt_q;
   assign vld    = (count_q != 2'd0);
   assign accept = bus.in_valid && rdy;
   assign push   = accept && !dec_brk;
   assign trap   = accept && dec_brk;
   assign pop    = vld && bus.out_ready;

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign bus.op        = op0_q;
   assign bus.illegal   = ill0_q;
   assign bus.tag_out   = tag0_q;
   assign bus.halt      = halt_q;

   // Next buffer state; vacated slots are zeroed so
   // the head reads as 0 when empty.
   always_comb begin
      count_d = count_q;
      halt_d  = halt_q | trap;
      op0_d   = op0_q;
      ill0_d  = ill0_q;
      tag0_d  = tag0_q;
      op1_d   = op1_q;
      ill1_d  = ill1_q;
      tag1_d  = tag1_q;
      unique case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               op0_d   = dec_op;
               ill0_d  = dec_ill;
               tag0_d  = bus.tag_in;
               count_d = 2'd1;
            end else begin
               op1_d   = dec_op;
               ill1_d  = dec_ill;
               tag1_d  = bus.tag_in;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               op0_d   = op1_q;
               ill0_d  = ill1_q;
               tag0_d  = tag1_q;
               count_d = 2'd1;
            end else begin
               op0_d   = '0;
               ill0_d  = 1'b0;
               tag0_d  = '0;
               count_d = 2'd0;
            end
            op1_d  = '0;
            ill1_d = 1'b0;
            tag1_d = '0;
         end
         2'b11: begin
            op0_d  = dec_op;
            ill0_d = dec_ill;
            tag0_d = bus.tag_in;
         end
         2'b00: ;
      endcase
   end

   // State registers, cleared by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 2'd0;
         halt_q  <= 1'b0;
         op0_q   <= '0;
         ill0_q  <= 1'b0;
         tag0_q  <= '0;
         op1_q   <= '0;
         ill1_q  <= 1'b0;
         tag1_q  <= '0;
      end else begin
         count_q <= count_d;
         halt_q  <= halt_d;
         op0_q   <= op0_d;
         ill0_q  <= ill0_d;
         tag0_q  <= tag0_d;
         op1_q   <= op1_d;
         ill1_q  <= ill1_d;
         tag1_q  <= tag1_d;
      end
   end

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl: decode vectors, directed
// back-pressure/break/reset runs, random stream.
module tb_ula_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ula_ctrl_if #(.TAG_W(5)) bus ();

   ula_ctrl #(.TAG_W(5)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0] a;
      logic [5:0] f;
      logic [5:0] o;
      logic [4:0] tag;
      logic [3:0] eop;
      logic       eill;
   } vec_t;

   typedef struct {
      logic [3:0] op;
      logic       ill;
      logic [4:0] tag;
   } ent_t;

   logic [5:0] r_code [12] = '{6'b100000, 6'b100001,
      6'b100010, 6'b100011, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010, 6'b101011,
      6'b011000, 6'b011001};
   logic [3:0] r_op [12] = '{4'b0010, 4'b0100,
      4'b0110, 4'b0101, 4'b0000, 4'b0001, 4'b0011,
      4'b1100, 4'b0111, 4'b1101, 4'b1000, 4'b1001};
   logic [5:0] i_code [8] = '{6'b001000, 6'b001001,
      6'b001010, 6'b001011, 6'b001100, 6'b001101,
      6'b001110, 6'b001111};
   logic [3:0] i_op [8] = '{4'b0010, 4'b0100,
      4'b0111, 4'b1101, 4'b0000, 4'b0001, 4'b0011,
      4'b1010};

   vec_t tv [16];
   ent_t mq [$];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // Lookup-table reference decode.
   function automatic void ref_dec(
      input  logic [1:0] a,
      input  logic [5:0] f,
      input  logic [5:0] o,
      output logic [3:0] op,
      output logic       ill);
      op  = 4'b0000;
      ill = 1'b1;
      if (a == 2'b00) begin
         op = 4'b0010; ill = 1'b0;
      end else if (a == 2'b01) begin
         op = 4'b0110; ill = 1'b0;
      end else if (a == 2'b10) begin
         for (int i = 0; i < 12; i++)
            if (r_code[i] == f) begin
               op = r_op[i]; ill = 1'b0;
            end
      end else begin
         for (int i = 0; i < 8; i++)
            if (i_code[i] == o) begin
               op = i_op[i]; ill = 1'b0;
            end
      end
   endfunction

   task automatic drive(input logic v,
                        input logic [1:0] a,
                        input logic [5:0] f,
                        input logic [5:0] o,
                        input logic [4:0] t);
      bus.in_valid = v;
      bus.alu_op   = a;
      bus.funct    = f;
      bus.opcode   = o;
      bus.tag_in   = t;
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] eop;
      logic       eill;
      logic       iv, orr, exp_rdy;
      logic [1:0] a;
      logic [5:0] f, o;
      logic [4:0] t;

      tv[0]  = '{2'b10, 6'b100000, 6'd0, 5'd1,  4'b0010, 1'b0};
      tv[1]  = '{2'b10, 6'b100011, 6'd0, 5'd2,  4'b0101, 1'b0};
      tv[2]  = '{2'b10, 6'b100111, 6'd0, 5'd3,  4'b1100, 1'b0};
      tv[3]  = '{2'b10, 6'b101010, 6'd0, 5'd4,  4'b0111, 1'b0};
      tv[4]  = '{2'b11, 6'd0, 6'b001111, 5'd7,  4'b1010, 1'b0};
      tv[5]  = '{2'b00, 6'd0, 6'd0,      5'd8,  4'b0010, 1'b0};
      tv[6]  = '{2'b01, 6'd0, 6'd0,      5'd9,  4'b0110, 1'b0};
      tv[7]  = '{2'b10, 6'b000111, 6'd0, 5'd10, 4'b0000, 1'b1};
      tv[8]  = '{2'b10, 6'b101011, 6'd0, 5'd11, 4'b1101, 1'b0};
      tv[9]  = '{2'b10, 6'b011001, 6'd0, 5'd12, 4'b1001, 1'b0};
      tv[10] = '{2'b11, 6'd0, 6'b001011, 5'd13, 4'b1101, 1'b0};
      tv[11] = '{2'b11, 6'd0, 6'b001110, 5'd14, 4'b0011, 1'b0};
      tv[12] = '{2'b11, 6'd0, 6'b000000, 5'd15, 4'b0000, 1'b1};
      tv[13] = '{2'b10, 6'b011000, 6'd0, 5'd16, 4'b1000, 1'b0};
      tv[14] = '{2'b11, 6'b001101, 6'b001101, 5'd17, 4'b0001, 1'b0};
      tv[15] = '{2'b10, 6'b100001, 6'd0, 5'd31, 4'b0100, 1'b0};

      drive(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
      bus.out_ready = 1'b1;
      do_reset();

      chk("rst in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst op", 32'(bus.op), 32'd0);
      chk("rst tag", 32'(bus.tag_out), 32'd0);
      chk("rst illegal", 32'(bus.illegal), 32'd0);
      chk("rst halt", 32'(bus.halt), 32'd0);

      // Back-to-back decode table.
      drive(1'b1, tv[0].a, tv[0].f, tv[0].o, tv[0].tag);
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("vec%0d valid", i),
             32'(bus.out_valid), 32'd1);
         chk($sformatf("vec%0d op", i),
             32'(bus.op), 32'(tv[i].eop));
         chk($sformatf("vec%0d ill", i),
             32'(bus.illegal), 32'(tv[i].eill));
         chk($sformatf("vec%0d tag", i),
             32'(bus.tag_out), 32'(tv[i].tag));
         chk($sformatf("vec%0d rdy", i),
             32'(bus.in_ready), 32'd1);
         if (i < 15)
            drive(1'b1, tv[i+1].a, tv[i+1].f,
                  tv[i+1].o, tv[i+1].tag);
         else
            drive(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
      end
      step();
      chk("drain valid", 32'(bus.out_valid), 32'd0);
      chk("drain op", 32'(bus.op), 32'd0);

      // Back-pressure with three pushes.
      bus.out_ready = 1'b0;
      drive(1'b1, 2'b10, 6'b100100, 6'd0, 5'd1);
      step();
      chk("bp1 op", 32'(bus.op), 32'b0000);
      chk("bp1 rdy", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 2'b10, 6'b100101, 6'd0, 5'd2);
      step();
      chk("bp2 rdy", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 2'b10, 6'b100110, 6'd0, 5'd3);
      step();
      chk("bp3 rdy", 32'(bus.in_ready), 32'd0);
      chk("bp3 hold tag", 32'(bus.tag_out), 32'd1);
      chk("bp3 hold valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      step();
      chk("bp4 op", 32'(bus.op), 32'b0001);
      chk("bp4 tag", 32'(bus.tag_out), 32'd2);
      chk("bp4 rdy", 32'(bus.in_ready), 32'd1);
      step();
      chk("bp5 op", 32'(bus.op), 32'b0011);
      chk("bp5 tag", 32'(bus.tag_out), 32'd3);
      drive(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
      step();
      chk("bp6 valid", 32'(bus.out_valid), 32'd0);

      // Break traps and halts.
      drive(1'b1, 2'b10, 6'b100001, 6'd0, 5'd4);
      step();
      chk("brk addu op", 32'(bus.op), 32'b0100);
      chk("brk halt0", 32'(bus.halt), 32'd0);
      drive(1'b1, 2'b10, 6'b001101, 6'd0, 5'd5);
      step();
      chk("brk halt", 32'(bus.halt), 32'd1);
      chk("brk rdy", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 2'b10, 6'b100000, 6'd0, 5'd6);
      for (int i = 0; i < 4; i++) begin
         chk("brk no valid", 32'(bus.out_valid), 32'd0);
         chk("brk no 1111",
             32'(bus.op == 4'b1111), 32'd0);
         chk("brk rdy stays", 32'(bus.in_ready), 32'd0);
         chk("brk halt stays", 32'(bus.halt), 32'd1);
         step();
      end

      // Reset mid-burst with a full buffer.
      drive(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
      do_reset();
      chk("rst2 halt", 32'(bus.halt), 32'd0);
      bus.out_ready = 1'b0;
      drive(1'b1, 2'b10, 6'b100101, 6'd0, 5'd9);
      step();
      step();
      chk("full rdy", 32'(bus.in_ready), 32'd0);
      drive(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
      rst = 1'b1;
      #1;
      chk("midrst valid", 32'(bus.out_valid), 32'd0);
      chk("midrst rdy", 32'(bus.in_ready), 32'd1);
      chk("midrst op", 32'(bus.op), 32'd0);
      chk("midrst tag", 32'(bus.tag_out), 32'd0);
      do_reset();

      // Random stream against a queue model.
      mq.delete();
      for (int c = 0; c < 400; c++) begin
         chk("rnd valid", 32'(bus.out_valid),
             32'(mq.size() != 0));
         exp_rdy = (mq.size() < 2);
         chk("rnd rdy", 32'(bus.in_ready), 32'(exp_rdy));
         if (mq.size() != 0) begin
            chk("rnd op", 32'(bus.op), 32'(mq[0].op));
            chk("rnd ill", 32'(bus.illegal),
                32'(mq[0].ill));
            chk("rnd tag", 32'(bus.tag_out),
                32'(mq[0].tag));
         end else begin
            chk("rnd op empty", 32'(bus.op), 32'd0);
         end
         iv  = 1'($urandom_range(1));
         orr = ($urandom_range(3) != 0);
         a   = 2'($urandom);
         if ($urandom_range(1) == 1)
            f = r_code[$urandom_range(11)];
         else
            f = 6'($urandom);
         if ($urandom_range(1) == 1)
            o = i_code[$urandom_range(7)];
         else
            o = 6'($urandom);
         if (a == 2'b10 && f == 6'b001101)
            f = 6'b100000;
         t = 5'($urandom);
         drive(iv, a, f, o, t);
         bus.out_ready = orr;
         @(posedge clk);
         if (mq.size() != 0 && orr)
            void'(mq.pop_front());
         if (iv && exp_rdy) begin
            ref_dec(a, f, o, eop, eill);
            mq.push_back('{eop, eill, t});
         end
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Registered ALU-control stage that sits in front of the ULA and produces its 4-bit operation select. It accepts decoded instruction fields from the main control unit through a valid/ready handshake and translates them into the ULA OP encoding. It buffers up to two operations under downstream back-pressure and traps `break` as a sticky halt instead of forwarding it to the ULA.

## Interface
Parameters:
- TAG_W, 5: width of the sideband tag carried alongside each op (destination register number).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- alu_op  in  2  main-control class: 00 add, 01 sub, 10 R-type (use funct), 11 I-type (use opcode).
- funct  in  6  R-type function field.
- opcode  in  6  instruction opcode.
- tag_in  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  op/tag/illegal are valid.
- out_ready  in  1  downstream accepts; a pop occurs when out_valid && out_ready at a rising edge.
- op  out  4  ULA operation select.
- tag_out  out  TAG_W  tag of the head entry.
- illegal  out  1  head entry came from an unrecognised encoding.
- halt  out  1  sticky; a break was accepted.

## Operation
- Decode, applied on push:
  - alu_op 00 → 0010.
  - alu_op 01 → 0110.
- alu_op 10, by funct:
  - 100000 add → 0010.
  - 100001 addu → 0100.
  - 100010 sub → 0110.
  - 100011 subu → 0101.
  - 100100 and → 0000.
  - 100101 or → 0001.
  - 100110 xor → 0011.
  - 100111 nor → 1100.
  - 101010 slt → 0111.
  - 101011 sltu → 1101.
  - 011000 mult → 1000.
  - 011001 multu → 1001.
  - 001101 break → trap.
- alu_op 11, by opcode:
  - 001000 addi → 0010.
  - 001001 addiu → 0100.
  - 001010 slti → 0111.
  - 001011 sltiu → 1101.
  - 001100 andi → 0000.
  - 001101 ori → 0001.
  - 001110 xori → 0011.
  - 001111 lui → 1010.
- Any other encoding: op = 0000, illegal = 1; the entry is still forwarded.
- OP 1101 means unsigned compare. The matching ULA extension for 1101 is a separate change.
- Trap on break: the entry is not pushed, halt sets, in_ready drops and stays low until reset.
- Entries already buffered when the trap occurs still drain normally.
- No encoding ever produces op = 1111.
- Buffer: 2-entry FIFO holding {op, illegal, tag}, with a 2-bit count.
  - in_ready = (count < 2) && !halt. It is a function of registers only, with no combinational path from out_ready.
  - out_valid = (count != 0). op/tag_out/illegal show the head entry and are 0 when empty.
- Simultaneous push and pop: at count 1, count stays 1 and the new entry becomes the head on the next cycle. At count 0 a pop cannot occur. At count 2 a push cannot occur.

## Timing
- Reset values: in_ready 1, out_valid 0, op 0000, tag_out 0, illegal 0, halt 0, count 0.
- Reset mid-operation discards all buffered entries.
- Latency: a push at edge k gives out_valid high in the cycle after edge k. This is a single register stage.
- Throughput: one op per cycle while out_ready is held high.
- Back-pressure: with out_ready low, two pushes are absorbed and in_ready is low from the following cycle. The first pop re-opens in_ready in the next cycle.
- Halt: high in the cycle after the break is accepted.
- Outputs hold stable while out_valid && !out_ready.

## Structure
- Shared package ula_pkg holds:
  - localparams for all 4-bit OP codes (OP_AND … OP_LUI, OP_SLTU = 1101, OP_BREAK = 1111 reserved/never emitted).
  - the funct and opcode constants listed above.
  - the alu_op class codes.
- The ULA is updated to import the same OP constants.
- Sub-module ula_op_decode: purely combinational {alu_op, funct, opcode} → {op, illegal, is_break}. ula_ctrl instantiates it at the push side and owns the FIFO and halt logic.

## Test plan
- Reset held 3 cycles then released → in_ready=1, out_valid=0, op=0, halt=0. Assert reset mid-burst with count=2 → count 0 and out_valid=0 within the same cycle.
- Stream alu_op=10 with funct 100000, 100011, 100111, 101010, out_ready=1 → out_valid one cycle after each push with op 0010, 0101, 1100, 0111 back-to-back and tags preserved.
- alu_op=11 opcode 001111 tag 7, then alu_op=00, then alu_op=01 → op 1010/tag 7, then 0010, then 0110.
- out_ready=0, push three ops (funct 100100, 100101, 100110) → first two accepted, in_ready=0 on the third. Raise out_ready → 0000 then 0001 emerge, the third is accepted after the first pop and emerges as 0011.
- Push funct 100001 then funct 001101 (break) then funct 100000 → 0100 emitted, halt=1 the next cycle, in_ready stays 0, the third op is never accepted, no 1111 seen.
- alu_op=10 funct 000111 → op=0000, illegal=1, out_valid=1.
